stack_guard: RTL and testbench
==============================

STACK_GUARD -- requirements
Module: stack_guard

Interface
REQ-001 Parameter DEPTH, default 16, entries in the governed register stack.
REQ-002 Parameter WIDTH, default 16, stack data width.
REQ-003 Parameter DW, default 5, depth-count width; SHALL satisfy 2**DW > DEPTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetq  input  1  asynchronous, active-low reset.
REQ-006 core_we  input  1  core write-top request.
REQ-007 core_delta  input  2  core stack move: 00 none, 01 push, 11 pop, 10 reserved.
REQ-008 core_wd  input  WIDTH  core write data.
REQ-009 core_stall  output  1  core SHALL hold its op unchanged while high.
REQ-010 stk_we  output  1  write enable to register stack.
REQ-011 stk_delta  output  2  move code to register stack.
REQ-012 stk_wd  output  WIDTH  write data to register stack.
REQ-013 unwind_req  input  1  request to pop stack down to unwind_target.
REQ-014 unwind_target  input  DW  target depth; sampled on acceptance.
REQ-015 unwind_busy  output  1  high while unwind pops are being issued.
REQ-016 unwind_done  output  1  one-cycle completion pulse.
REQ-017 depth  output  DW  current tracked depth, 0..DEPTH.
REQ-018 hiwater  output  DW  maximum depth since reset or last err_clr.
REQ-019 ovf  output  1  sticky overflow flag.
REQ-020 unf  output  1  sticky underflow flag.
REQ-021 err_clr  input  1  clears ovf, unf; reloads hiwater with depth.
REQ-022 irq  output  1  level interrupt, equals ovf OR unf.

Function
REQ-023 FSM states IDLE, UNWIND, DONE.
REQ-024 IDLE, unwind_req low: stk_we/stk_delta/stk_wd SHALL equal core_we/core_delta/core_wd combinationally (zero latency); core_stall low.
REQ-025 Reserved core_delta 10 SHALL be forwarded as 00, core_we passed unchanged, depth unchanged, no flag.
REQ-026 Forwarded push with depth<DEPTH: depth+1 next cycle.
REQ-027 Forwarded push with depth==DEPTH: depth stays DEPTH, ovf set next cycle.
REQ-028 Forwarded pop with depth>0: depth-1 next cycle.
REQ-029 Forwarded pop with depth==0: depth stays 0, unf set next cycle.
REQ-030 Write-only (we=1, delta 00) SHALL not change depth.
REQ-031 hiwater SHALL update to new depth whenever new depth exceeds it.
REQ-032 IDLE, unwind_req high: core_stall high, core op not forwarded (stk_we=0, stk_delta=00), target latched; next state UNWIND if target<depth, else DONE.
REQ-033 UNWIND: each cycle stk_we=0, stk_delta=11, depth-1, core_stall=1, unwind_busy=1; when depth-1 equals latched target, next state DONE.
REQ-034 DONE: unwind_done=1 for exactly one cycle, core_stall low, core op forwarded per REQ-024..031, unwind_req ignored; next state IDLE.
REQ-035 Unwind pops SHALL never set unf.
REQ-036 err_clr coincident with a flag-setting event: set wins; hiwater reload uses post-update depth.
REQ-037 unwind_req held high in IDLE after DONE SHALL start a new unwind.

Reset
REQ-038 resetq low SHALL immediately force state IDLE, depth 0, hiwater 0, ovf 0, unf 0, unwind_busy 0, unwind_done 0, including mid-unwind.
REQ-039 During reset, stk_we=0, stk_delta=00, core_stall=0.

Verification
REQ-040 From reset, 16 pushes then 1 push -> depth 16, ovf=1 and irq=1 after 17th, all 17 pushes visible on stk_delta.
REQ-041 From reset, one pop -> stk_delta=11 forwarded, depth 0, unf=1.
REQ-042 Depth 10, unwind_req with target 3 -> 1 accept cycle, unwind_busy for 7 cycles with 7 pops, unwind_done pulse, depth 3, core_stall high across accept+UNWIND.
REQ-043 Depth 5, unwind_req with target 12 -> no pops, DONE next cycle, unwind_done one pulse, depth 5.
REQ-044 Depth 16, err_clr with push same cycle -> ovf remains 1; hiwater 16.
REQ-045 resetq low on 3rd UNWIND cycle -> depth 0, unwind_busy 0, no unwind_done pulse, stk_delta=00 immediately.

Source files
------------

// File: rtl/stack_guard.sv
// Guard between a core and its register stack: tracks depth, flags overflow
// and underflow, and can unwind the stack down to a target depth on request.
module stack_guard #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int DW    = 5
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             core_we,
  input  logic [1:0]       core_delta,
  input  logic [WIDTH-1:0] core_wd,
  output logic             core_stall,
  output logic             stk_we,
  output logic [1:0]       stk_delta,
  output logic [WIDTH-1:0] stk_wd,
  input  logic             unwind_req,
  input  logic [DW-1:0]    unwind_target,
  output logic             unwind_busy,
  output logic             unwind_done,
  output logic [DW-1:0]    depth,
  output logic [DW-1:0]    hiwater,
  output logic             ovf,
  output logic             unf,
  input  logic             err_clr,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE = 2'b00, UNWIND = 2'b01, DONE = 2'b10} state_t;

  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
  localparam logic [DW-1:0] ONE_C   = DW'(1);
  localparam logic [DW-1:0] ZERO_C  = DW'(0);

  state_t          state_r, state_nx_s;
  logic [DW-1:0]   depth_r, hiwater_r, target_r;
  logic [DW-1:0]   depth_nx_s, hiwater_nx_s;
  logic            ovf_r, unf_r, irq_r, busy_r, done_r;
  logic            ovf_nx_s, unf_nx_s, ovf_set_s, unf_set_s;
  logic            accept_s, fwd_s, unwind_pop_s;
  logic [1:0]      fwd_delta_s;

  // Decode which path owns the stack port this cycle.
  always_comb begin
    accept_s     = 1'b0;
    fwd_s        = 1'b0;
    unwind_pop_s = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = unwind_req;
        fwd_s    = ~unwind_req;
      end
      UNWIND: unwind_pop_s = 1'b1;
      DONE:   fwd_s        = 1'b1;
      default: fwd_s       = 1'b0;
    endcase
  end

  // Zero-latency forwarding to the stack; everything is quiet while in reset.
  always_comb begin
    if (core_delta == 2'b10) begin
      fwd_delta_s = 2'b00;
    end else begin
      fwd_delta_s = core_delta;
    end
    if (!resetq) begin
      stk_we     = 1'b0;
      stk_delta  = 2'b00;
      core_stall = 1'b0;
    end else begin
      stk_we     = fwd_s & core_we;
      core_stall = accept_s | unwind_pop_s;
      if (unwind_pop_s) begin
        stk_delta = 2'b11;
      end else if (fwd_s) begin
        stk_delta = fwd_delta_s;
      end else begin
        stk_delta = 2'b00;
      end
    end
  end

  assign stk_wd = core_wd;

  // Next depth, flag events and sticky flag / high-water bookkeeping.
  always_comb begin
    depth_nx_s = depth_r;
    ovf_set_s  = 1'b0;
    unf_set_s  = 1'b0;
    if (unwind_pop_s) begin
      if (depth_r != ZERO_C) begin
        depth_nx_s = depth_r - ONE_C;
      end else begin
        depth_nx_s = depth_r;
      end
    end else if (fwd_s && fwd_delta_s == 2'b01) begin
      if (depth_r < DEPTH_C) begin
        depth_nx_s = depth_r + ONE_C;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else if (fwd_s && fwd_delta_s == 2'b11) begin
      if (depth_r != ZERO_C) begin
        depth_nx_s = depth_r - ONE_C;
      end else begin
        unf_set_s = 1'b1;
      end
    end else begin
      depth_nx_s = depth_r;
    end
    // A flag event in the same cycle as err_clr wins over the clear.
    ovf_nx_s = ovf_set_s | (ovf_r & ~err_clr);
    unf_nx_s = unf_set_s | (unf_r & ~err_clr);
    if (err_clr) begin
      hiwater_nx_s = depth_nx_s;
    end else if (depth_nx_s > hiwater_r) begin
      hiwater_nx_s = depth_nx_s;
    end else begin
      hiwater_nx_s = hiwater_r;
    end
  end

  // Unwind sequencing.
  always_comb begin
    state_nx_s = IDLE;
    case (state_r)
      IDLE: begin
        if (unwind_req && (unwind_target < depth_r)) begin
          state_nx_s = UNWIND;
        end else if (unwind_req) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      UNWIND: begin
        if (depth_nx_s <= target_r) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = UNWIND;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_r   <= IDLE;
      depth_r   <= ZERO_C;
      hiwater_r <= ZERO_C;
      target_r  <= ZERO_C;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
      irq_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      depth_r   <= depth_nx_s;
      hiwater_r <= hiwater_nx_s;
      target_r  <= accept_s ? unwind_target : target_r;
      ovf_r     <= ovf_nx_s;
      unf_r     <= unf_nx_s;
      irq_r     <= ovf_nx_s | unf_nx_s;
      busy_r    <= (state_nx_s == UNWIND);
      done_r    <= (state_nx_s == DONE);
    end
  end

  assign depth       = depth_r;
  assign hiwater     = hiwater_r;
  assign ovf         = ovf_r;
  assign unf         = unf_r;
  assign irq         = irq_r;
  assign unwind_busy = busy_r;
  assign unwind_done = done_r;

endmodule

// File: tb/tb_stack_guard.sv
// Directed bench for stack_guard with a cycle-level behavioural model.
module tb_stack_guard;

  logic        clk = 1'b0;
  logic        resetq;
  logic        core_we;
  logic [1:0]  core_delta;
  logic [15:0] core_wd;
  logic        core_stall, stk_we;
  logic [1:0]  stk_delta;
  logic [15:0] stk_wd;
  logic        unwind_req;
  logic [4:0]  unwind_target;
  logic        unwind_busy, unwind_done;
  logic [4:0]  depth, hiwater;
  logic        ovf, unf, err_clr, irq;

  int total = 0;
  int bad   = 0;
  int push_seen, pop_seen, busy_seen, done_seen, stall_seen;

  // model state: depth, high-water, sticky flags, pending unwind pops, DONE cycle
  int m_depth = 0, m_hi = 0, m_pops = 0;
  bit m_ovf = 1'b0, m_unf = 1'b0, m_done = 1'b0;

  stack_guard #(.DEPTH(16), .WIDTH(16), .DW(5)) dut (
    .clk(clk), .resetq(resetq), .core_we(core_we), .core_delta(core_delta),
    .core_wd(core_wd), .core_stall(core_stall), .stk_we(stk_we),
    .stk_delta(stk_delta), .stk_wd(stk_wd), .unwind_req(unwind_req),
    .unwind_target(unwind_target), .unwind_busy(unwind_busy),
    .unwind_done(unwind_done), .depth(depth), .hiwater(hiwater), .ovf(ovf),
    .unf(unf), .err_clr(err_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compare DUT against the model on every falling edge, then advance the model.
  always @(negedge clk) begin : cmp
    bit busy, accept, fwd, os, us;
    int ed, ewe, nd;
    if (!resetq) begin
      m_depth = 0; m_hi = 0; m_pops = 0; m_ovf = 1'b0; m_unf = 1'b0; m_done = 1'b0;
      chk("rst_stk_we", stk_we, 0);
      chk("rst_stk_delta", stk_delta, 0);
      chk("rst_stall", core_stall, 0);
      chk("rst_depth", depth, 0);
      chk("rst_hiwater", hiwater, 0);
      chk("rst_flags", {ovf, unf, irq}, 0);
      chk("rst_busy_done", {unwind_busy, unwind_done}, 0);
    end else begin
      busy   = (m_pops > 0);
      accept = !busy && !m_done && unwind_req;
      fwd    = !busy && !accept;
      ed     = busy ? 3 : (accept ? 0 : ((core_delta == 2'b10) ? 0 : int'(core_delta)));
      ewe    = fwd ? int'(core_we) : 0;
      chk("stk_we", stk_we, ewe);
      chk("stk_delta", stk_delta, ed);
      chk("stk_wd", stk_wd, core_wd);
      chk("core_stall", core_stall, int'(accept || busy));
      chk("depth", depth, m_depth);
      chk("hiwater", hiwater, m_hi);
      chk("ovf", ovf, m_ovf);
      chk("unf", unf, m_unf);
      chk("irq", irq, int'(m_ovf || m_unf));
      chk("unwind_busy", unwind_busy, int'(busy));
      chk("unwind_done", unwind_done, m_done);
      if (stk_delta == 2'b01) push_seen++;
      if (stk_delta == 2'b11) pop_seen++;
      if (unwind_busy) busy_seen++;
      if (unwind_done) done_seen++;
      if (core_stall) stall_seen++;
      nd = m_depth; os = 1'b0; us = 1'b0;
      if (accept) begin
        m_pops = (int'(unwind_target) < m_depth) ? m_depth - int'(unwind_target) : 0;
        m_done = (m_pops == 0);
      end else if (busy) begin
        nd--;
        m_pops--;
        m_done = (m_pops == 0);
      end else begin
        m_done = 1'b0;
        if (ed == 1) begin
          if (nd < 16) nd++; else os = 1'b1;
        end else if (ed == 3) begin
          if (nd > 0) nd--; else us = 1'b1;
        end
      end
      m_depth = nd;
      if (err_clr) begin
        m_ovf = os; m_unf = us; m_hi = nd;
      end else begin
        m_ovf = m_ovf | os; m_unf = m_unf | us;
        if (nd > m_hi) m_hi = nd;
      end
    end
  end

  task automatic step(input logic we, input logic [1:0] d, input logic [15:0] wd,
                      input logic req, input logic [4:0] tgt, input logic clr);
    core_we = we; core_delta = d; core_wd = wd;
    unwind_req = req; unwind_target = tgt; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    push_seen = 0; pop_seen = 0; busy_seen = 0; done_seen = 0; stall_seen = 0;
  endtask

  initial begin
    resetq = 1'b0;
    core_we = 1'b0; core_delta = 2'b00; core_wd = 16'h0000;
    unwind_req = 1'b0; unwind_target = 5'd0; err_clr = 1'b0;
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_depth_lit", depth, 0);
    resetq = 1'b1;

    // 17 pushes from empty: saturate at 16, overflow on the last
    for (int i = 0; i < 17; i++) step(1'b1, 2'b01, 16'(i), 1'b0, 5'd0, 1'b0);
    chk("fill_depth", depth, 16);
    chk("fill_model_depth", m_depth, 16);
    chk("fill_ovf", ovf, 1);
    chk("fill_irq", irq, 1);
    chk("fill_pushes", push_seen, 17);
    chk("fill_hiwater", hiwater, 16);

    // err_clr with a push at full depth: overflow re-sets
    step(1'b0, 2'b01, 16'h0, 1'b0, 5'd0, 1'b1);
    chk("clr_push_ovf", ovf, 1);
    chk("clr_push_hi", hiwater, 16);
    step(1'b0, 2'b00, 16'h0, 1'b0, 5'd0, 1'b1);
    chk("clr_ovf", ovf, 0);
    chk("clr_irq", irq, 0);

    // reserved move and write-only leave depth alone
    step(1'b1, 2'b10, 16'hABCD, 1'b0, 5'd0, 1'b0);
    step(1'b1, 2'b00, 16'h1234, 1'b0, 5'd0, 1'b0);
    chk("rsvd_depth", depth, 16);

    resetq = 1'b0;
    @(posedge clk);
    #1;
    resetq = 1'b1;

    // pop from empty
    step(1'b0, 2'b11, 16'h0, 1'b0, 5'd0, 1'b0);
    chk("unf_depth", depth, 0);
    chk("unf_flag", unf, 1);
    chk("unf_model", m_unf, 1);
    chk("unf_irq", irq, 1);
    step(1'b0, 2'b00, 16'h0, 1'b0, 5'd0, 1'b1);
    chk("unf_clr", unf, 0);

    // unwind 10 -> 3
    for (int i = 0; i < 10; i++) step(1'b1, 2'b01, 16'(i), 1'b0, 5'd0, 1'b0);
    chk("hi_10", hiwater, 10);
    clr_counts();
    step(1'b0, 2'b00, 16'h0, 1'b1, 5'd3, 1'b0);
    repeat (9) step(1'b0, 2'b00, 16'h0, 1'b0, 5'd0, 1'b0);
    chk("uw_busy_cycles", busy_seen, 7);
    chk("uw_pops", pop_seen, 7);
    chk("uw_done_pulses", done_seen, 1);
    chk("uw_stall_cycles", stall_seen, 8);
    chk("uw_depth", depth, 3);
    chk("uw_model_depth", m_depth, 3);
    chk("uw_hiwater", hiwater, 10);

    // target above depth: straight to DONE
    repeat (2) step(1'b1, 2'b01, 16'h0, 1'b0, 5'd0, 1'b0);
    clr_counts();
    step(1'b0, 2'b00, 16'h0, 1'b1, 5'd12, 1'b0);
    repeat (2) step(1'b0, 2'b00, 16'h0, 1'b0, 5'd0, 1'b0);
    chk("hi_tgt_pops", pop_seen, 0);
    chk("hi_tgt_done", done_seen, 1);
    chk("hi_tgt_busy", busy_seen, 0);
    chk("hi_tgt_depth", depth, 5);

    // request held high restarts after DONE; pushes forwarded in DONE
    clr_counts();
    repeat (8) step(1'b1, 2'b01, 16'h5A5A, 1'b1, 5'd2, 1'b0);
    step(1'b0, 2'b00, 16'h0, 1'b0, 5'd0, 1'b0);
    chk("held_done", done_seen, 2);
    chk("held_depth", depth, 3);

    // reset in the third UNWIND cycle
    repeat (7) step(1'b1, 2'b01, 16'h0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 2'b00, 16'h0, 1'b1, 5'd0, 1'b0);
    repeat (2) step(1'b0, 2'b00, 16'h0, 1'b0, 5'd0, 1'b0);
    clr_counts();
    core_we = 1'b1; core_delta = 2'b01;
    resetq = 1'b0;
    #1;
    chk("mid_rst_depth", depth, 0);
    chk("mid_rst_busy", unwind_busy, 0);
    chk("mid_rst_delta", stk_delta, 0);
    chk("mid_rst_we", stk_we, 0);
    @(posedge clk);
    #1;
    resetq = 1'b1;
    repeat (3) step(1'b0, 2'b00, 16'h0, 1'b0, 5'd0, 1'b0);
    chk("mid_rst_no_done", done_seen, 0);
    chk("mid_rst_depth_after", depth, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
